// File: rtl/wb_arbiter.sv
// wb_arbiter: merges non-stalling ALU results and buffered long-latency results
// into one registered register-file write port, with a pending-write scoreboard.
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_WIDTH-1:0]         mem_rd,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic [(1<<ADDR_WIDTH)-1:0]    pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          regwrite,
  output logic [ADDR_WIDTH-1:0]         rd,
  output logic [DATA_WIDTH-1:0]         wd
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NR = 1 << ADDR_WIDTH;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  logic [ADDR_WIDTH-1:0] q_rd [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NR-1:0] pend_nxt;
  // ready looks only at registered occupancy so a same-cycle pop never widens it
  assign mem_ready = rst_n && fifo_count != FULL;
  assign push = mem_valid && mem_ready;
  assign pop = !alu_valid && fifo_count != '0;
  assign sel_rd = alu_valid ? alu_rd : q_rd[rp];
  assign sel_data = alu_valid ? alu_data : q_data[rp];
  always_comb begin
    pend_nxt = pending;
    if (pop) pend_nxt[q_rd[rp]] = 1'b0;
    if (issue_valid) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp] <= mem_rd;
      q_data[wp] <= mem_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      pending <= '0;
      regwrite <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      pending <= pend_nxt;
      regwrite <= (alu_valid || pop) && sel_rd != '0;
      if (alu_valid || pop) begin
        rd <= sel_rd;
        wd <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, hand sequences and random traffic
// checked against a queue-based model of the writeback arbiter.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n, alu_valid, mem_valid, mem_ready, issue_valid, regwrite;
  logic [4:0] alu_rd, mem_rd, issue_rd, rd;
  logic [31:0] alu_data, mem_data, wd, pending;
  logic [2:0] fifo_count;

  wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
    .fifo_count(fifo_count), .regwrite(regwrite), .rd(rd), .wd(wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
  ent_t mq[$];
  logic [31:0] m_pend;
  logic m_rw;
  logic [4:0] m_rd;
  logic [31:0] m_wd;
  logic acc;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic iv; logic [4:0] ir; logic rn;
    logic erw; logic [4:0] erd; logic [31:0] ewd; logic [2:0] ecnt; logic [31:0] epend;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances by the spec rules and every output is checked.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic iv, input logic [4:0] ir, input logic rn);
    ent_t e;
    logic rdy;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    issue_valid = iv; issue_rd = ir; rst_n = rn;
    #1;
    rdy = rn && (mq.size() != DEPTH);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, rdy});
    acc = mv && rdy;
    if (!rn) begin
      mq.delete();
      m_pend = '0; m_rw = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      if (av) begin
        m_rw = ar != 0; m_rd = ar; m_wd = ad;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        m_rw = e.rd != 0; m_rd = e.rd; m_wd = e.data;
        m_pend[e.rd] = 1'b0;
      end else m_rw = 1'b0;
      if (acc) mq.push_back(ent_t'{mr, md});
      if (iv && ir != 0) m_pend[ir] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("regwrite", {31'b0, regwrite}, {31'b0, m_rw});
    chk("rd", {27'b0, rd}, {27'b0, m_rd});
    chk("wd", wd, m_wd);
    chk("fifo_count", {29'b0, fifo_count}, mq.size());
    chk("pending", pending, m_pend);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int idx;
    mq.delete();
    m_pend = '0; m_rw = 0; m_rd = 0; m_wd = 0; acc = 0;
    //          av ar  ad            mv mr md       iv ir rn  rw rd  wd            cnt pend
    tbl[0]  = '{0, 0, 0,            0, 0, 0,       0, 0, 0,  0, 0, 0,            0, 0};
    tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 1,  1, 5, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  0, 5, 32'hDEADBEEF, 0, 0};
    tbl[3]  = '{0, 0, 0,            0, 0, 0,       1, 7, 1,  0, 5, 32'hDEADBEEF, 0, 32'h80};
    tbl[4]  = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  0, 5, 32'hDEADBEEF, 0, 32'h80};
    tbl[5]  = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  0, 5, 32'hDEADBEEF, 0, 32'h80};
    tbl[6]  = '{0, 0, 0,            1, 7, 32'h1234, 0, 0, 1, 0, 5, 32'hDEADBEEF, 1, 32'h80};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  1, 7, 32'h1234,     0, 0};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  0, 7, 32'h1234,     0, 0};
    tbl[9]  = '{1, 0, 32'hFFFF,     0, 0, 0,       0, 0, 1,  0, 0, 32'hFFFF,     0, 0};
    tbl[10] = '{0, 0, 0,            1, 0, 32'hAAAA, 0, 0, 1, 0, 0, 32'hFFFF,     1, 0};
    tbl[11] = '{0, 0, 0,            0, 0, 0,       0, 0, 1,  0, 0, 32'hAAAA,     0, 0};
    tbl[12] = '{0, 0, 0,            0, 0, 0,       1, 0, 1,  0, 0, 32'hAAAA,     0, 0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md,
           tbl[i].iv, tbl[i].ir, tbl[i].rn);
      chk($sformatf("t%0d_rw", i), {31'b0, regwrite}, {31'b0, tbl[i].erw});
      chk($sformatf("t%0d_rd", i), {27'b0, rd}, {27'b0, tbl[i].erd});
      chk($sformatf("t%0d_wd", i), wd, tbl[i].ewd);
      chk($sformatf("t%0d_cnt", i), {29'b0, fifo_count}, {29'b0, tbl[i].ecnt});
      chk($sformatf("t%0d_pend", i), pending, tbl[i].epend);
    end

    // ALU starves the FIFO; producer holds each item until accepted
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 1, c, idx < 6, 5'(8 + idx), 32'h100 + idx, 0, 0, 1);
      if (acc) idx++;
    end
    chk("starve_cnt", {29'b0, fifo_count}, 4);
    chk("starve_acc", idx, 4);
    chk("starve_ready", {31'b0, mem_ready}, 0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("drain%0d_rw", k), {31'b0, regwrite}, 1);
      chk($sformatf("drain%0d_rd", k), {27'b0, rd}, 8 + k);
      chk($sformatf("drain%0d_wd", k), wd, 32'h100 + k);
    end
    idle();
    chk("drain_done", {31'b0, regwrite}, 0);

    // simultaneous push and pop, pointer wrap over 2*DEPTH+1 entries
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      step(0, 0, 0, 1, 5'(20 + i), 32'h500 + i, 0, 0, 1);
      chk($sformatf("pp%0d_cnt", i), {29'b0, fifo_count}, 1);
      if (i > 0) begin
        chk($sformatf("pp%0d_rd", i), {27'b0, rd}, 20 + i - 1);
        chk($sformatf("pp%0d_wd", i), wd, 32'h500 + i - 1);
      end
    end
    idle();
    chk("pp_last_rd", {27'b0, rd}, 20 + 2 * DEPTH);
    chk("pp_empty", {29'b0, fifo_count}, 0);

    // reset with buffered entries and a pending bit
    step(0, 0, 0, 0, 0, 0, 1, 3, 1);
    for (int j = 0; j < 3; j++) step(1, 0, 0, 1, 5'(12 + j), 32'h900 + j, 0, 0, 1);
    chk("pre_rst_cnt", {29'b0, fifo_count}, 3);
    chk("pre_rst_pend", pending, 32'h8);
    step(0, 0, 0, 1, 9, 9, 0, 0, 0);
    chk("rst_cnt", {29'b0, fifo_count}, 0);
    chk("rst_pend", pending, 0);
    chk("rst_rw", {31'b0, regwrite}, 0);
    for (int j = 0; j < 4; j++) begin
      idle();
      chk($sformatf("post_rst%0d_rw", j), {31'b0, regwrite}, 0);
    end

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom), $urandom_range(0, 49) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the register file's single write port.
- Merges two result sources into one registered write stream:
  - single-cycle ALU results, which cannot stall;
  - long-latency results from the load/mul path, which use a valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a pending-destination scoreboard so decode can detect hazards on in-flight long-latency writes.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register index width (32 registers).
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, >=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- mem_valid  input  1  long-latency result offered.
- mem_ready  output  1  FIFO can accept a long-latency result.
- mem_rd  input  ADDR_WIDTH  long-latency destination register.
- mem_data  input  DATA_WIDTH  long-latency result.
- issue_valid  input  1  long-latency op issued this cycle.
- issue_rd  input  ADDR_WIDTH  destination of issued op.
- pending  output  2**ADDR_WIDTH  scoreboard, bit i = write to xi outstanding.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- regwrite  output  1  register-file write enable (registered).
- rd  output  ADDR_WIDTH  register-file write index (registered).
- wd  output  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset: rst_n sampled low at an edge clears the following:
  - regwrite, rd, wd, pending and fifo_count become 0.
  - FIFO read and write pointers become 0.
  - mem_ready is 0 while rst_n is low.
  - Reset mid-operation discards all buffered results and pending bits.
- mem_ready = rst_n && (fifo_count != FIFO_DEPTH). This is combinational from registered state only, with no dependence on the same-cycle pop.
- Push: mem_valid && mem_ready at an edge writes {mem_rd, mem_data} at the write pointer.
  - The write pointer increments and wraps modulo FIFO_DEPTH.
- Arbitration, once per cycle:
  - ALU has absolute priority: if alu_valid, the output registers load alu_rd and alu_data.
  - Otherwise, if fifo_count != 0, the FIFO head is popped into the output registers.
  - Otherwise regwrite <= 0, and rd and wd hold their values.
- Push and pop in the same cycle: fifo_count is unchanged and both pointers advance.
- Latency:
  - ALU result presented at cycle N: regwrite=1 at cycle N+1.
  - Long-latency result accepted at cycle N into an empty FIFO with no ALU traffic: regwrite=1 at cycle N+2.
- x0 handling: any selected entry with destination 0 produces regwrite=0 at the output.
  - The entry is still consumed or popped.
  - rd and wd still update.
- Ordering: long-latency results are written in acceptance order.
  - No reordering against other long-latency results.
  - ALU writes may overtake buffered long-latency writes.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending[issue_rd] at the edge.
  - A FIFO pop of entry rd=r clears pending[r] at the same edge it loads the output registers.
  - ALU writes never touch pending.
  - Set and clear of the same bit in one cycle: set wins.
  - pending[0] is constant 0.
- Starvation: continuous alu_valid blocks FIFO drain. Back-pressure then appears only as mem_ready=0; no data is lost.
- Overflow safety: a mem_valid while mem_ready=0 is ignored, and the producer must hold it.
- fifo_count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle 1 -> cycle 2: regwrite=1, rd=5, wd=0xDEADBEEF; cycle 3: regwrite=0.
- issue_valid, issue_rd=7 at cycle 1; mem_valid, mem_rd=7, mem_data=0x1234 at cycle 4 with no ALU traffic -> pending[7]=1 from cycle 2; regwrite=1, rd=7, wd=0x1234 at cycle 6; pending[7]=0 at cycle 6.
- alu_valid held high for 10 cycles while pushing 6 mem results -> mem_ready=0 once fifo_count=4 and only 4 accepted; after ALU stops, 4 writes emitted in push order on consecutive cycles.
- FIFO holds one entry, with a mem push and a pop (no ALU) in the same cycle -> fifo_count stays 1; entries emerge in order; pointer wrap exercised over 2*FIFO_DEPTH+1 entries without loss.
- ALU rd=0 data 0xFFFF and mem rd=0 -> regwrite stays 0 for both; the FIFO entry is still popped; pending stays all-zero.
- rst_n low for one edge with 3 entries buffered and pending[3]=1 -> next cycle fifo_count=0, pending=0, regwrite=0; no buffered entry is ever written.
